// File: rtl/adder_pipelined_pkg.sv
// rtl/adder_pipelined_pkg.sv - shared mode encoding and width check for the pipelined adder
`ifndef ADDER_PIPELINED_PKG_SV
`define ADDER_PIPELINED_PKG_SV

// Elaboration-time guard: chunks must tile the operand exactly.
`define ADDER_PIPELINED_WIDTH_CHECK(n_, s_) \
  if ((s_) < 1 || (n_) < 2 || ((n_) % (s_)) != 0) begin : g_width_check \
    $error("adder_pipelined: N must be >= 2 and an exact multiple of STAGES"); \
  end

package adder_pipelined_pkg;

  // Value of the sub input for each operation.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

`endif

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational W-bit ripple of full_adder cells
module adder_chunk
  import adder_pipelined_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // Each bit keeps its own carry nets so the ripple is a plain chain of
  // distinct signals rather than a feedback path through one vector.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic cin;
    logic cout;

    if (i == 0) begin : g_first
      assign cin = ci;
    end else begin : g_next
      assign cin = g_bit[i-1].cout;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (cin),
      .s  (s[i]),
      .co (cout)
    );
  end

  assign co    = g_bit[W-1].cout;
  assign c_msb = g_bit[W-1].cin;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipelined.sv
// rtl/adder_pipelined.sv - STAGES-deep chunked add/subtract with valid/ready flow control
module adder_pipelined
  import adder_pipelined_pkg::*;
#(
  parameter int  N      = 8,
  parameter int  STAGES = 2,
  localparam int CHUNK  = N / STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  `ADDER_PIPELINED_WIDTH_CHECK(N, STAGES)

  localparam int LAST = STAGES - 1;

  // Subtraction is x + ~y + 1; the caller's carry is irrelevant then.
  logic [N-1:0] y_eff;
  logic         c_eff;

  assign y_eff = (sub == MODE_SUB) ? ~y : y;
  assign c_eff = (sub == MODE_SUB) ? 1'b1 : c_in;

  // Per-stage state: operand bits not yet consumed (consumed bits cleared),
  // sum bits completed so far, and the carry out of the chunk just added.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [N-1:0]      x_q [STAGES];
  logic [N-1:0]      x_d [STAGES];
  logic [N-1:0]      y_q [STAGES];
  logic [N-1:0]      y_d [STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic [N-1:0]      s_d [STAGES];
  logic              cmsb_q, cmsb_d;

  // What each stage would load: the input port for stage 0, otherwise the
  // registers of the stage before it.
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [N-1:0]      src_x [STAGES];
  logic [N-1:0]      src_y [STAGES];
  logic [N-1:0]      src_s [STAGES];

  logic [CHUNK-1:0]  chunk_s [STAGES];
  logic [STAGES-1:0] chunk_co;
  logic [STAGES-1:0] chunk_cmsb;

  logic [STAGES-1:0] load;
  logic              ready_chain;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid;
      assign src_c[k] = c_eff;
      assign src_x[k] = x;
      assign src_y[k] = y_eff;
      assign src_s[k] = '0;
    end else begin : g_body
      assign src_v[k] = valid_q[k-1];
      assign src_c[k] = carry_q[k-1];
      assign src_x[k] = x_q[k-1];
      assign src_y[k] = y_q[k-1];
      assign src_s[k] = s_q[k-1];
    end

    adder_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a     (src_x[k][k*CHUNK +: CHUNK]),
      .b     (src_y[k][k*CHUNK +: CHUNK]),
      .ci    (src_c[k]),
      .s     (chunk_s[k]),
      .co    (chunk_co[k]),
      .c_msb (chunk_cmsb[k])
    );
  end

  // Load enables ripple back from out_ready: a stage may load when it is
  // empty or when the stage after it is loading this cycle.
  always_comb begin
    load        = '0;
    ready_chain = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      load[k]     = !valid_q[k] || ready_chain;
      ready_chain = load[k];
    end
  end

  assign in_ready = load[0];

  // Next state: valids shift (bubbles included) whenever a stage loads, data
  // registers only move when a real beat arrives so idle stages stay quiet.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    for (int k = 0; k < STAGES; k++) begin
      x_d[k] = x_q[k];
      y_d[k] = y_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = src_v[k];
      end
      if (load[k] && src_v[k]) begin
        x_d[k]                     = src_x[k];
        x_d[k][k*CHUNK +: CHUNK]   = '0;
        y_d[k]                     = src_y[k];
        y_d[k][k*CHUNK +: CHUNK]   = '0;
        s_d[k]                     = src_s[k];
        s_d[k][k*CHUNK +: CHUNK]   = chunk_s[k];
        carry_d[k]                 = chunk_co[k];
      end
    end
    if (load[LAST] && src_v[LAST]) begin
      cmsb_d = chunk_cmsb[LAST];
    end
  end

  // Stage registers; reset drops every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = carry_q[LAST];
  assign ovf       = cmsb_q ^ carry_q[LAST];

  // The last stage has no operand bits left to hand on, and only the final
  // chunk's carry into its MSB matters for overflow.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{x_q[LAST], y_q[LAST], chunk_cmsb};

endmodule

// File: tb/tb_adder_pipelined.sv
// tb/tb_adder_pipelined.sv - self-checking bench for adder_pipelined
module tb_adder_pipelined;
  import adder_pipelined_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=8, STAGES=2
  logic       in_valid = 1'b0, in_ready, c_in = 1'b0, sub = 1'b0;
  logic       out_valid, out_ready = 1'b0, c_out, ovf;
  logic [7:0] x = '0, y = '0, sum;

  // N=4, STAGES=1
  logic       v4_in_valid = 1'b0, v4_in_ready, v4_c_in = 1'b0, v4_sub = 1'b0;
  logic       v4_out_valid, v4_out_ready = 1'b1, v4_c_out, v4_ovf;
  logic [3:0] v4_x = '0, v4_y = '0, v4_sum;

  // N=16, STAGES=4
  logic        w_in_valid = 1'b0, w_in_ready, w_c_in = 1'b0, w_sub = 1'b0;
  logic        w_out_valid, w_out_ready = 1'b1, w_c_out, w_ovf;
  logic [15:0] w_x = '0, w_y = '0, w_sum;

  adder_pipelined #(.N(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  adder_pipelined #(.N(4), .STAGES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .x(v4_x), .y(v4_y), .c_in(v4_c_in), .sub(v4_sub), .out_valid(v4_out_valid),
    .out_ready(v4_out_ready), .sum(v4_sum), .c_out(v4_c_out), .ovf(v4_ovf)
  );

  adder_pipelined #(.N(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .x(w_x), .y(w_y), .c_in(w_c_in), .sub(w_sub), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf)
  );

  // Reference: {ovf, c_out, sum} from integer arithmetic on the operands.
  function automatic logic [9:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic s);
    int         ia, ib, res;
    logic [8:0] wide;
    logic       co, ov;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (s) begin
      wide = {1'b0, a} - {1'b0, b};
      co   = (a >= b);
      res  = ia - ib;
    end else begin
      wide = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      co   = wide[8];
      res  = ia + ib + int'(ci);
    end
    ov = (res > 127) || (res < -128);
    return {ov, co, wide[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the idle 8-bit pipe and wait for its result.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, output logic rdy, output int lat,
                          output logic [7:0] rs, output logic rc, output logic ro);
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    c_in      = ci;
    sub       = s;
    out_ready = 1'b1;
    #1;
    rdy = in_ready;
    tick();
    in_valid = 1'b0;
    x        = 8'($urandom);
    y        = 8'($urandom);
    lat      = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    rs = sum;
    rc = c_out;
    ro = ovf;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (v4_out_valid !== 1'b0 || w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid: got %b%b expected 00", v4_out_valid, w_out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (v4_in_ready !== 1'b1 || w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b%b expected 11", v4_in_ready, w_in_ready); end
    tick();
  endtask

  task automatic test_add_wrap();
    logic rdy, rc, ro;
    int lat;
    logic [7:0] rs;
    send_one(8'hFF, 8'h01, 1'b0, MODE_ADD, rdy, lat, rs, rc, ro);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wrap_in_ready: got %b expected 1", rdy); end
    checks++; if (lat != 2) begin errors++; $display("FAIL wrap_latency: got %0d expected 2", lat); end
    checks++; if (rs !== 8'h00) begin errors++; $display("FAIL wrap_sum: got %h expected 00", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL wrap_c_out: got %b expected 1", rc); end
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", ro); end
  endtask

  task automatic test_overflow();
    logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h05};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h07};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic       ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es [3] = '{8'h80, 8'h7F, 8'hFE};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    logic rdy, rc, ro;
    int lat;
    logic [7:0] rs;
    for (int i = 0; i < 3; i++) begin
      send_one(ta[i], tb[i], tc[i], ts[i], rdy, lat, rs, rc, ro);
      checks++; if (rs !== es[i]) begin errors++; $display("FAIL ovf_sum[%0d]: got %h expected %h", i, rs, es[i]); end
      checks++; if (rc !== ec[i]) begin errors++; $display("FAIL ovf_c_out[%0d]: got %b expected %b", i, rc, ec[i]); end
      checks++; if (ro !== eo[i]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, ro, eo[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    int         got_cyc [$];
    int         sent = 0;
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      x         = 8'(sent + 1);
      y         = 8'(sent + 1);
      c_in      = 1'b0;
      sub       = MODE_ADD;
      #1;
      if (cyc < 5) begin
        checks++; if (in_ready !== 1'(cyc < 2)) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready, 1'(cyc < 2)); end
      end
      if (cyc >= 2 && cyc < 5) begin
        checks++; if (out_valid !== 1'b1 || sum !== 8'h02) begin errors++; $display("FAIL bp_hold cyc%0d: got valid %b sum %h expected valid 1 sum 02", cyc, out_valid, sum); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got.push_back(sum);
        got_cyc.push_back(cyc);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== 8'(2 * (i + 1))) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], 8'(2 * (i + 1))); end
        checks++; if (got_cyc[i] != 5 + i) begin errors++; $display("FAIL bp_timing[%0d]: got cycle %0d expected %0d", i, got_cyc[i], 5 + i); end
      end
    end
  endtask

  task automatic test_streaming();
    logic [9:0] expq [$];
    logic [9:0] e;
    int n_in = 0, n_out = 0, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n_out < 16; cyc++) begin
      in_valid = (n_in < 16);
      x        = 8'($urandom);
      y        = 8'($urandom);
      c_in     = 1'($urandom);
      sub      = 1'($urandom);
      #1;
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc%0d: got %b expected 1", cyc, in_ready); end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_add8(x, y, c_in, sub));
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++; $display("FAIL stream_spurious cyc%0d: got result %h expected none", cyc, sum);
        end else begin
          e = expq.pop_front();
          checks++; if (sum !== e[7:0]) begin errors++; $display("FAIL stream_sum #%0d: got %h expected %h", n_out, sum, e[7:0]); end
          checks++; if (c_out !== e[8]) begin errors++; $display("FAIL stream_c_out #%0d: got %b expected %b", n_out, c_out, e[8]); end
          checks++; if (ovf !== e[9]) begin errors++; $display("FAIL stream_ovf #%0d: got %b expected %b", n_out, ovf, e[9]); end
        end
        if (n_out > 0) begin
          checks++; if (cyc != last + 1) begin errors++; $display("FAIL stream_rate #%0d: got cycle %0d expected %0d", n_out, cyc, last + 1); end
        end
        last = cyc;
        n_out++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (n_out != 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", n_out); end
  endtask

  task automatic test_reset_midflight();
    logic rdy, rc, ro;
    int lat;
    int stale = 0;
    logic [7:0] rs;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    c_in      = 1'b0;
    sub       = MODE_ADD;
    x = 8'h11; y = 8'h22;
    tick();
    x = 8'h33; y = 8'h44;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_immediate: got %b expected 0", out_valid); end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      if (out_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d results expected 0", stale); end
    send_one(8'h10, 8'h20, 1'b0, MODE_ADD, rdy, lat, rs, rc, ro);
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_latency: got %0d expected 2", lat); end
    checks++; if (rs !== 8'h30) begin errors++; $display("FAIL midrst_sum: got %h expected 30", rs); end
  endtask

  task automatic test_config_sweep();
    logic [15:0] wa [2] = '{16'h00FF, 16'h0100};
    logic [15:0] wb [2] = '{16'h0001, 16'h0001};
    logic        wsb [2] = '{1'b0, 1'b1};
    logic [15:0] ws [2] = '{16'h0100, 16'h00FF};
    logic        wc [2] = '{1'b0, 1'b1};
    int lat;
    v4_x = 4'hF; v4_y = 4'h1; v4_c_in = 1'b0; v4_sub = MODE_ADD;
    v4_in_valid = 1'b1;
    #1;
    checks++; if (v4_in_ready !== 1'b1) begin errors++; $display("FAIL n4_in_ready: got %b expected 1", v4_in_ready); end
    tick();
    v4_in_valid = 1'b0;
    checks++; if (v4_out_valid !== 1'b1) begin errors++; $display("FAIL n4_latency: got valid %b expected 1 after 1 cycle", v4_out_valid); end
    checks++; if (v4_sum !== 4'h0 || v4_c_out !== 1'b1 || v4_ovf !== 1'b0) begin errors++; $display("FAIL n4_result: got sum %h c %b ovf %b expected 0 1 0", v4_sum, v4_c_out, v4_ovf); end
    tick();
    checks++; if (v4_out_valid !== 1'b0) begin errors++; $display("FAIL n4_drain: got %b expected 0", v4_out_valid); end
    for (int i = 0; i < 2; i++) begin
      w_x = wa[i]; w_y = wb[i]; w_c_in = 1'b0; w_sub = wsb[i];
      w_in_valid = 1'b1;
      tick();
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 12) begin
        tick();
        lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL n16_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (w_sum !== ws[i]) begin errors++; $display("FAIL n16_sum[%0d]: got %h expected %h", i, w_sum, ws[i]); end
      checks++; if (w_c_out !== wc[i] || w_ovf !== 1'b0) begin errors++; $display("FAIL n16_flags[%0d]: got c %b ovf %b expected c %b ovf 0", i, w_c_out, w_ovf, wc[i]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_overflow();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    test_config_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at time 100000, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_pipelined.md
Name: adder_pipelined

Overview:
- Parametrised, pipelined successor to the team's N-bit carry-ripple adder.
- Splits an N-bit add/subtract into STAGES ripple chunks, with one chunk and one register slice per stage.
- Uses a valid/ready handshake on both sides and full backpressure, so it can sit in streaming datapaths.
- Adds a subtract mode and a signed-overflow flag.

Parameters:
- N, 8: operand width in bits. Must be >= 2.
- STAGES, 2: pipeline depth and number of chunks. N % STAGES == 0 is required; elaboration errors otherwise.
- CHUNK, N/STAGES: derived chunk width, not overridable.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- x  in  N  operand A.
- y  in  N  operand B.
- c_in  in  1  carry in; ignored when sub=1.
- sub  in  1  0 = x+y+c_in; 1 = x-y, computed as x+~y+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  N  result, modulo 2^N.
- c_out  out  1  carry out of the MSB. When sub=1, c_out=1 means no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - All stage valid flags = 0; all data registers = 0.
  - out_valid=0, sum=0, c_out=0, ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Transfers:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - A result is consumed when out_valid && out_ready.
- Stage k (0..STAGES-1) holds: valid_k, the remaining upper operand bits, completed low sum bits, running carry, and carry into bit N-1 (captured in the last stage only).
- Stage 0 adds chunk 0 of x and y_eff (y_eff = sub ? ~y : y) with carry c_eff (c_eff = sub ? 1 : c_in). Stage k adds chunk k using the carry registered by stage k-1.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure. Throughput: 1 beat per cycle.
- Advance rule:
  - stall_k = valid_k && !(stage k+1 can load). The last stage's "next can load" is out_ready.
  - Stage k loads when !valid_k || !stall_k.
  - in_ready = stage-0 load condition. This is combinational from out_ready through the chain; no skid buffer.
- Capacity: exactly STAGES beats in flight. Results emerge in acceptance order, with no drops or duplicates.
- Output hold: while out_valid=1 and out_ready=0, sum, c_out and ovf hold stable.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: one beat exits and one enters in the same cycle, and in_ready stays 1.
  - Empty pipe with in_valid=0: valids stay 0 and data registers do not toggle (load gated by valid for power).
- Bubbles: an invalid upstream stage shifts a 0 into valid_k. Bubbles collapse when downstream is stalled.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- X-safety: x, y, c_in and sub are not sampled when in_valid=0.
- STAGES=1 degenerates to a single registered N-bit adder with 1-cycle latency.

Decomposition:
- Shared package/header holds:
  - Mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - A width-check macro used for the N % STAGES assertion.
- One sub-module, adder_chunk: combinational CHUNK-bit ripple of full-adder cells.
  - Ports: a, b, ci, s, co, c_msb. c_msb is the carry into the chunk MSB.
  - Instantiated once per stage through a generate loop.
  - Reuses the existing full_adder cell.

Test Plan (N=8, STAGES=2 unless noted):
- Add wrap: x=8'hFF, y=8'h01, c_in=0, sub=0 -> 2 cycles later sum=8'h00, c_out=1, ovf=0.
- Signed overflow: x=8'h7F, y=8'h01, sub=0 -> sum=8'h80, c_out=0, ovf=1. Then sub=1, x=8'h80, y=8'h01 -> sum=8'h7F, c_out=1, ovf=1. Then sub=1, x=8'h05, y=8'h07 (c_in=1, must be ignored) -> sum=8'hFE, c_out=0, ovf=0.
- Backpressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) back-to-back with out_ready=0 for the first 5 cycles -> in_ready drops after 2 beats are accepted. Outputs 8'h02 stays stable while stalled. Then release -> 02, 04, 06, 08 in order, one per cycle.
- Full-rate streaming: 16 random beats with in_valid=1 and out_ready=1 -> 16 results, one per cycle, each matching a reference model (x+y+c_in or x-y), in_ready constantly 1.
- Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle -> out_valid=0 immediately and no stale result appears afterwards. Next beat 8'h10+8'h20 -> sum=8'h30 after 2 cycles.
- Config sweep: N=4/STAGES=1 gives latency 1 cycle, 4'hF+4'h1 -> 0, c_out=1. N=16/STAGES=4, 16'h00FF+16'h0001 -> 16'h0100 after 4 cycles.
